// File: rtl/rsa_pipe_pkg.sv
// Shared definitions for the MEM/WB pipeline slice.
// Contents:
//   DEF_ARQ, DEF_MEMORY_ADDR_SIZE, DEF_TIMEOUT : default datapath width, data-memory address
//                                               width, and the maximum number of mem_ready
//                                               wait cycles
//   wb_state_e                                 : MEM/WB controller state encoding
package rsa_pipe_pkg;

    localparam int unsigned DEF_ARQ              = 16;
    localparam int unsigned DEF_MEMORY_ADDR_SIZE = 13;
    localparam int unsigned DEF_TIMEOUT          = 15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        WB       = 2'd2
    } wb_state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Counts the cycles spent waiting for the data memory and flags the last permitted cycle.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset
//   clear_i   : restart the count from zero (a new operation was accepted)
//   enable_i  : one more cycle waited without completion
//   expired_o : combinational; high on the LIMIT-th waiting cycle when that cycle also
//               has no completion
module mem_wait_counter
    import rsa_pipe_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_TIMEOUT,
    parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [CNT_W-1:0] count_q;

    // count_q holds the number of wait cycles already completed, so the LIMIT-th wait
    // cycle is the one that starts with count_q == LIMIT-1.
    assign expired_o = enable_i && (count_q == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i || expired_o) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB stage: takes one operation from EXE, runs the data-memory handshake for loads and
// stores, and produces a single-cycle register-file write strobe.
// Optional feature: when the macro WB_FORWARD_EN is defined, fwd_valid/fwd_reg/fwd_data
// mirror the writeback outputs for EXE bypassing.
// Ports:
//   clk, rst                        : clock (rising edge), synchronous active-high reset
//   exe_valid, wb_en, rd_en_mem,
//   wr_en_mem, mux_mem, alu_result,
//   store_data, dest_reg            : operation presented by EXE
//   mem_req, mem_we, mem_addr,
//   mem_wdata                       : data-memory request (held stable until mem_ready)
//   mem_rdata, mem_ready            : data-memory response
//   stall_out                       : EXE must hold its operation
//   wb_result_out, wr_reg_en_out,
//   wb_reg_out                      : register-file write port
//   err_out                         : sticky memory-timeout flag
module mem_wb_pipe
    import rsa_pipe_pkg::*;
#(
    parameter int unsigned ARQ              = DEF_ARQ,
    parameter int unsigned MEMORY_ADDR_SIZE = DEF_MEMORY_ADDR_SIZE,
    parameter int unsigned TIMEOUT          = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        exe_valid,
    input  logic                        wb_en,
    input  logic                        rd_en_mem,
    input  logic                        wr_en_mem,
    input  logic                        mux_mem,
    input  logic [ARQ-1:0]              alu_result,
    input  logic [ARQ-1:0]              store_data,
    input  logic [3:0]                  dest_reg,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
    output logic [ARQ-1:0]              mem_wdata,
    input  logic [ARQ-1:0]              mem_rdata,
    input  logic                        mem_ready,
    output logic                        stall_out,
    output logic [ARQ-1:0]              wb_result_out,
    output logic                        wr_reg_en_out,
    output logic [3:0]                  wb_reg_out,
    output logic                        err_out
`ifdef WB_FORWARD_EN
    ,
    output logic                        fwd_valid,
    output logic [3:0]                  fwd_reg,
    output logic [ARQ-1:0]              fwd_data
`endif
);

    wb_state_e state_q;

    logic                        mem_req_q;
    logic                        mem_we_q;
    logic [MEMORY_ADDR_SIZE-1:0] mem_addr_q;
    logic [ARQ-1:0]              mem_wdata_q;
    logic [ARQ-1:0]              wb_result_q;
    logic                        wr_reg_en_q;
    logic [3:0]                  wb_reg_q;
    logic                        err_q;

    // Fields of the accepted operation needed once the memory responds.
    logic           op_wb_en_q;
    logic           op_load_q;
    logic           op_mux_q;
    logic [ARQ-1:0] op_alu_q;
    logic [3:0]     op_dest_q;

    logic is_mem;
    logic is_load;
    logic accept;
    logic wait_en;
    logic expired;

    assign is_mem  = rd_en_mem | wr_en_mem;
    // A request with both enables set is a store.
    assign is_load = rd_en_mem & ~wr_en_mem;
    assign accept  = exe_valid && (state_q != MEM_WAIT);
    assign wait_en = (state_q == MEM_WAIT) && !mem_ready;

    // A memory op presented in IDLE/WB is taken, but EXE still stalls until it completes.
    assign stall_out = (state_q == MEM_WAIT) || (exe_valid && is_mem);

    mem_wait_counter #(
        .LIMIT (TIMEOUT)
    ) u_wait_cnt (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (accept),
        .enable_i  (wait_en),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_result_q <= '0;
            wr_reg_en_q <= 1'b0;
            wb_reg_q    <= '0;
            err_q       <= 1'b0;
            op_wb_en_q  <= 1'b0;
            op_load_q   <= 1'b0;
            op_mux_q    <= 1'b0;
            op_alu_q    <= '0;
            op_dest_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE, WB: begin
                    wr_reg_en_q <= 1'b0;
                    if (accept) begin
                        op_wb_en_q <= wb_en;
                        op_load_q  <= is_load;
                        op_mux_q   <= mux_mem;
                        op_alu_q   <= alu_result;
                        op_dest_q  <= dest_reg;
                        if (is_mem) begin
                            state_q     <= MEM_WAIT;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= wr_en_mem;
                            mem_addr_q  <= alu_result[MEMORY_ADDR_SIZE-1:0];
                            mem_wdata_q <= store_data;
                        end else begin
                            // Register writes to r0 are dropped: it reads as zero.
                            state_q     <= WB;
                            wr_reg_en_q <= wb_en && (dest_reg != 4'd0);
                            wb_result_q <= alu_result;
                            wb_reg_q    <= dest_reg;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_q     <= WB;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        wr_reg_en_q <= op_wb_en_q && op_load_q && (op_dest_q != 4'd0);
                        wb_result_q <= op_mux_q ? mem_rdata : op_alu_q;
                        wb_reg_q    <= op_dest_q;
                    end else if (expired) begin
                        // Give up on the access; the operation retires without writeback.
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mem_req_q   <= 1'b0;
                    mem_we_q    <= 1'b0;
                    wr_reg_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign wb_result_out = wb_result_q;
    assign wr_reg_en_out = wr_reg_en_q;
    assign wb_reg_out    = wb_reg_q;
    assign err_out       = err_q;

`ifdef WB_FORWARD_EN
    assign fwd_valid = wr_reg_en_q;
    assign fwd_reg   = wb_reg_q;
    assign fwd_data  = wb_result_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
module tb_mem_wb_pipe;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid;
    logic        wb_en;
    logic        rd_en_mem;
    logic        wr_en_mem;
    logic        mux_mem;
    logic [15:0] alu_result;
    logic [15:0] store_data;
    logic [3:0]  dest_reg;
    logic        mem_req;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        stall_out;
    logic [15:0] wb_result_out;
    logic        wr_reg_en_out;
    logic [3:0]  wb_reg_out;
    logic        err_out;

    mem_wb_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .exe_valid     (exe_valid),
        .wb_en         (wb_en),
        .rd_en_mem     (rd_en_mem),
        .wr_en_mem     (wr_en_mem),
        .mux_mem       (mux_mem),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .dest_reg      (dest_reg),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .stall_out     (stall_out),
        .wb_result_out (wb_result_out),
        .wr_reg_en_out (wr_reg_en_out),
        .wb_reg_out    (wb_reg_out),
        .err_out       (err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  rd_idx;
    } wb_exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        mux;
        logic        wben;
        logic [15:0] alu;
        logic [15:0] sdata;
        logic [3:0]  dest;
        int          ready_dly;  // 0 = never ready
        logic [15:0] rdata;
        int          exp_req;
        logic        exp_we;
        logic        exp_err;
        logic        exp_wb;
        logic [15:0] exp_res;
    } vec_t;

    wb_exp_t sb[$];
    vec_t    vecs[9];
    int      checks = 0;
    int      errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exe_valid  = 1'b0;
        wb_en      = 1'b0;
        rd_en_mem  = 1'b0;
        wr_en_mem  = 1'b0;
        mux_mem    = 1'b0;
        alu_result = '0;
        store_data = '0;
        dest_reg   = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic present(input logic rd, input logic wr, input logic mux, input logic wben,
                           input logic [15:0] alu, input logic [15:0] sdata,
                           input logic [3:0] dest);
        exe_valid  = 1'b1;
        rd_en_mem  = rd;
        wr_en_mem  = wr;
        mux_mem    = mux;
        wb_en      = wben;
        alu_result = alu;
        store_data = sdata;
        dest_reg   = dest;
    endtask

    // Scoreboard consumer: every write strobe must match the oldest expected writeback.
    always @(negedge clk) begin
        if (wr_reg_en_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got reg %0d data %0h expected no write at %0t",
                         wb_reg_out, wb_result_out, $time);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                chk("wb_result", {16'h0, wb_result_out}, {16'h0, e.res});
                chk("wb_reg", {28'h0, wb_reg_out}, {28'h0, e.rd_idx});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //                rd    wr    mux   wben  alu       sdata     dest  rdy rdata    req we   err  wb   res
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd17,   16'h0,    4'd3, 0,  16'h0,    0, 1'b0, 1'b0, 1'b1, 16'd17};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd42,   16'h0,    4'd0, 0,  16'h0,    0, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0055, 16'h0,    4'd5, 0,  16'h0,    0, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0,    4'd7, 3,  16'hBEEF, 3, 1'b0, 1'b0, 1'b1, 16'hBEEF};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h1FFF, 16'h1234, 4'd2, 1,  16'h0,    1, 1'b1, 1'b0, 1'b0, 16'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0100, 16'h5555, 4'd4, 2,  16'hDEAD, 2, 1'b1, 1'b0, 1'b0, 16'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0123, 16'h0,    4'd9, 5,  16'hAAAA, 5, 1'b0, 1'b0, 1'b1, 16'h0123};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0200, 16'h0,    4'd1, 15, 16'h7777, 15, 1'b0, 1'b0, 1'b1, 16'h7777};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0300, 16'h0,    4'd6, 0,  16'h1111, 15, 1'b0, 1'b1, 1'b0, 16'h0};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", {19'h0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", {16'h0, mem_wdata}, 32'h0);
        chk("rst_wr_en", {31'h0, wr_reg_en_out}, 32'h0);
        chk("rst_wb_result", {16'h0, wb_result_out}, 32'h0);
        chk("rst_wb_reg", {28'h0, wb_reg_out}, 32'h0);
        chk("rst_err", {31'h0, err_out}, 32'h0);
        chk("rst_stall", {31'h0, stall_out}, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            int          n;
            logic [12:0] ea;
            ea = vecs[i].alu[12:0];
            present(vecs[i].rd, vecs[i].wr, vecs[i].mux, vecs[i].wben,
                    vecs[i].alu, vecs[i].sdata, vecs[i].dest);
            #1;
            chk($sformatf("v%0d_stall_present", i), {31'h0, stall_out},
                {31'h0, vecs[i].rd | vecs[i].wr});
            if (vecs[i].exp_wb) sb.push_back('{vecs[i].exp_res, vecs[i].dest});
            tick();
            idle_inputs();
            n = 0;
            while (mem_req && n < 40) begin
                chk($sformatf("v%0d_addr", i), {19'h0, mem_addr}, {19'h0, ea});
                chk($sformatf("v%0d_we", i), {31'h0, mem_we}, {31'h0, vecs[i].exp_we});
                if (vecs[i].exp_we)
                    chk($sformatf("v%0d_wdata", i), {16'h0, mem_wdata}, {16'h0, vecs[i].sdata});
                chk($sformatf("v%0d_stall_wait", i), {31'h0, stall_out}, 32'h1);
                if (n + 1 == vecs[i].ready_dly) begin
                    mem_ready = 1'b1;
                    mem_rdata = vecs[i].rdata;
                end
                tick();
                mem_ready = 1'b0;
                mem_rdata = '0;
                n++;
            end
            chk($sformatf("v%0d_req_cycles", i), n, vecs[i].exp_req);
            chk($sformatf("v%0d_err", i), {31'h0, err_out}, {31'h0, vecs[i].exp_err});
            tick();
            tick();
            chk($sformatf("v%0d_wb_drained", i), sb.size(), 0);
        end

        // Reset during MEM_WAIT: request dropped, nothing written back, sticky error cleared.
        present(1'b1, 1'b0, 1'b1, 1'b1, 16'h0077, 16'h0, 4'd8);
        tick();
        idle_inputs();
        tick();
        chk("rstw_req_before", {31'h0, mem_req}, 32'h1);
        rst = 1'b1;
        tick();
        chk("rstw_req", {31'h0, mem_req}, 32'h0);
        chk("rstw_err", {31'h0, err_out}, 32'h0);
        chk("rstw_stall", {31'h0, stall_out}, 32'h0);
        rst = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 16'hCAFE;
        tick();
        idle_inputs();
        tick();
        tick();
        chk("rstw_req_after", {31'h0, mem_req}, 32'h0);

        // Back-to-back ALU ops: second is accepted from WB, giving two consecutive strobes.
        present(1'b0, 1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h0, 4'd10);
        sb.push_back('{16'h0A0A, 4'd10});
        tick();
        present(1'b0, 1'b0, 1'b0, 1'b1, 16'h0B0B, 16'h0, 4'd11);
        sb.push_back('{16'h0B0B, 4'd11});
        #1;
        chk("b2b_stall", {31'h0, stall_out}, 32'h0);
        chk("b2b_first_en", {31'h0, wr_reg_en_out}, 32'h1);
        tick();
        idle_inputs();
        chk("b2b_second_en", {31'h0, wr_reg_en_out}, 32'h1);
        tick();
        chk("b2b_end_en", {31'h0, wr_reg_en_out}, 32'h0);
        tick();
        chk("b2b_drained", sb.size(), 0);

        // An op presented during MEM_WAIT is ignored.
        present(1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0, 4'd12);
        sb.push_back('{16'h4321, 4'd12});
        tick();
        idle_inputs();
        tick();
        present(1'b0, 1'b0, 1'b0, 1'b1, 16'd99, 16'h0, 4'd5);
        #1;
        chk("ign_stall", {31'h0, stall_out}, 32'h1);
        tick();
        idle_inputs();
        mem_ready = 1'b1;
        mem_rdata = 16'h4321;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        chk("ign_wb_en", {31'h0, wr_reg_en_out}, 32'h1);
        tick();
        tick();
        tick();
        chk("ign_drained", sb.size(), 0);
        chk("final_err", {31'h0, err_out}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
